// File: rtl/aes_dec_pkg.sv
// Shared types and constants for the AES-128 decryption input path.
package aes_dec_pkg;

   typedef enum logic [1:0] {
      LOAD  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } loader_state_t;

   localparam int AES_BLOCK_W     = 128;
   localparam int AES_WORD_W      = 32;
   localparam int AES_WORDS       = 4;
   localparam int AES_DEC_LATENCY = 14;

endpackage

// File: rtl/decrypt_input_loader_latency_timer.sv
// Loadable down-counter that measures the decryption core's fixed latency.
// It stops at zero and only runs again after the next load.
module latency_timer #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic [CNT_W-1:0] count,
   output logic             zero
);

   // Load takes priority; otherwise count down and hold at zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (count != '0) begin
         count <= count - 1'b1;
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/decrypt_input_loader.sv
// Feeds 32-bit ciphertext words into a 128-bit block for the AES-128
// decryption core, starts the core, and strobes when its output is valid.
//
// state | meaning
// LOAD  | accepting words; word_cnt selects the lane written next
// ISSUE | block complete; decrypt_enable high for this one cycle
// WAIT  | core running; capture fires in the cycle the timer reads zero
module decrypt_input_loader
   import aes_dec_pkg::*;
#(
   parameter int WORD_W  = AES_WORD_W,
   parameter int BLOCK_W = AES_BLOCK_W,
   parameter int LATENCY = AES_DEC_LATENCY,
   parameter int CNT_W   = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   input  logic [WORD_W-1:0]  in_data,
   output logic               in_ready,
   input  logic               abort,
   output logic [BLOCK_W-1:0] cipher_data,
   output logic               decrypt_enable,
   output logic               busy,
   output logic               capture,
   output logic [CNT_W-1:0]   blocks_issued
);

   localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(LATENCY - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   loader_state_t    state;
   logic [1:0]       word_cnt;
   logic             tmr_load;
   logic [CNT_W-1:0] tmr_count;
   logic             tmr_zero;

   // The timer is armed in ISSUE so it reads LATENCY-1 in the first WAIT cycle.
   assign tmr_load = (state == ISSUE);

   latency_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (tmr_load),
      .load_val (LAT_LOAD),
      .count    (tmr_count),
      .zero     (tmr_zero)
   );

   assign in_ready = (state == LOAD);
   assign busy     = (state != LOAD);

   // Sequencer: word packing, core start pulse, latency wait and capture strobe.
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= LOAD;
         word_cnt       <= '0;
         cipher_data    <= '0;
         decrypt_enable <= 1'b0;
         capture        <= 1'b0;
         blocks_issued  <= '0;
      end else begin
         decrypt_enable <= 1'b0;
         capture        <= 1'b0;
         unique case (state)
            LOAD: begin
               // abort beats a simultaneous handshake; that word is dropped
               if (abort) begin
                  word_cnt <= '0;
               end else if (in_valid) begin
                  for (int i = 0; i < AES_WORDS; i++) begin
                     if (word_cnt == 2'(i)) begin
                        cipher_data[BLOCK_W-1-WORD_W*i -: WORD_W] <= in_data;
                     end
                  end
                  word_cnt <= word_cnt + 2'd1;
                  if (word_cnt == 2'd3) begin
                     state          <= ISSUE;
                     decrypt_enable <= 1'b1;
                  end
               end
            end
            ISSUE: begin
               blocks_issued <= blocks_issued + 1'b1;
               state         <= WAIT;
            end
            WAIT: begin
               // capture is registered one cycle ahead so it coincides with zero
               if (tmr_zero) begin
                  state <= LOAD;
               end else if (tmr_count == CNT_ONE) begin
                  capture <= 1'b1;
               end
            end
            default: begin
               state <= LOAD;
            end
         endcase
      end
   end

endmodule
